// File: rtl/dma_mmio_pkg.sv
// Shared constants, encodings and helpers for the DMA MMIO register file.
// Optional per-lane write strobes are enabled with DMA_MMIO_WSTRB_EN.
package dma_mmio_pkg;

    localparam int FIELD_W = 27;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word offsets (addr[3:2]) inside a ring block and inside the global block.
    localparam logic [1:0] RING_BASE_OFF      = 2'd0;
    localparam logic [1:0] RING_HIGH_OFF      = 2'd1;
    localparam logic [1:0] RING_SIZE_OFF      = 2'd2;
    localparam logic [1:0] RING_CTRL_OFF      = 2'd3;
    localparam logic [7:0] GLB_BLOCK          = 8'h80;
    localparam logic [1:0] GLB_VERSION_OFF    = 2'd0;
    localparam logic [1:0] GLB_IRQ_STATUS_OFF = 2'd1;
    localparam logic [1:0] GLB_IRQ_ENABLE_OFF = 2'd2;

    typedef enum logic {
        DIR_S2C = 1'b0,
        DIR_C2S = 1'b1
    } ring_dir_e;

    // Packed so that {ch, dir} is numerically the ring index 2*ch + dir.
    typedef struct packed {
        logic [2:0] ch;
        ring_dir_e  dir;
    } ring_idx_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        strb_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    function automatic logic [FIELD_W-1:0] merge_field(input logic [FIELD_W-1:0] old_v,
                                                       input logic [FIELD_W-1:0] new_v,
                                                       input logic [FIELD_W-1:0] mask);
        merge_field = (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/dma_mmio_axil_if.sv
// AXI-Lite slave front end: one-entry AW/W holding registers, B and R response
// registers, and a simple wr_*/rd_* strobe interface toward the register core.
module dma_mmio_axil_if
    import dma_mmio_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        awvalid_i,
    input  logic [31:0] awaddr_i,
    output logic        awready_o,
    input  logic        wvalid_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        wready_o,
    output logic        bvalid_o,
    output logic [1:0]  bresp_o,
    input  logic        bready_i,
    input  logic        arvalid_i,
    input  logic [31:0] araddr_i,
    output logic        arready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    input  logic        rready_i,
    output logic        wr_en_o,
    output logic [11:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_strb_o,
    input  logic        wr_err_i,
    output logic        rd_en_o,
    output logic [11:0] rd_addr_o,
    input  logic [31:0] rd_data_i,
    input  logic        rd_err_i
);

    logic        aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [11:0] aw_addr_q, aw_addr_d;
    logic [31:0] w_data_q, w_data_d, rdata_q, rdata_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic        awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic        unused_addr;

    assign unused_addr = ^{awaddr_i[31:12], araddr_i[31:12]};

    assign wr_en_o   = aw_full_q & w_full_q & ~bvalid_q;
    assign wr_addr_o = aw_addr_q;
    assign wr_data_o = w_data_q;
    assign wr_strb_o = w_strb_q;
    assign rd_en_o   = arvalid_i & arready_q;
    assign rd_addr_o = araddr_i[11:0];

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign arready_o = arready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

    // Next state of holding registers, responses and the registered readies.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (wr_en_o) begin
            aw_full_d = 1'b0;
        end else if (awvalid_i && awready_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr_i[11:0];
        end else begin
            aw_full_d = aw_full_q;
        end
        if (wr_en_o) begin
            w_full_d = 1'b0;
        end else if (wvalid_i && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = wdata_i;
            w_strb_d = wstrb_i;
        end else begin
            w_full_d = w_full_q;
        end
        if (wr_en_o) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err_i ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && bready_i) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
        if (rd_en_o) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_err_i ? 32'h0000_0000 : rd_data_i;
            rresp_d  = rd_err_i ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && rready_i) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
        awready_d = ~aw_full_d;
        wready_d  = ~w_full_d;
        arready_d = ~rvalid_d;
    end

    // Interface state registers; reset drops any pending transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= 12'h000;
            w_full_q  <= 1'b0;
            w_data_q  <= 32'h0000_0000;
            w_strb_q  <= 4'h0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0000_0000;
            rresp_q   <= RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
        end
    end

endmodule

// File: rtl/dma_mmio_regfile.sv
// DMA ring register file behind an AXI-Lite slave: per-ring BASE/HIGH/SIZE/CTRL
// plus VERSION/IRQ_STATUS/IRQ_ENABLE. Define DMA_MMIO_WSTRB_EN for byte-lane writes.
module dma_mmio_regfile
    import dma_mmio_pkg::*;
#(
    parameter int          NUM_CH  = 2,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic                            user_clk,
    input  logic                            user_reset,
    input  logic                            s_axi_lite_awvalid,
    input  logic [31:0]                     s_axi_lite_awaddr,
    output logic                            s_axi_lite_awready,
    input  logic                            s_axi_lite_wvalid,
    input  logic [31:0]                     s_axi_lite_wdata,
    input  logic [3:0]                      s_axi_lite_wstrb,
    output logic                            s_axi_lite_wready,
    output logic                            s_axi_lite_bvalid,
    output logic [1:0]                      s_axi_lite_bresp,
    input  logic                            s_axi_lite_bready,
    input  logic                            s_axi_lite_arvalid,
    input  logic [31:0]                     s_axi_lite_araddr,
    output logic                            s_axi_lite_arready,
    output logic                            s_axi_lite_rvalid,
    output logic [31:0]                     s_axi_lite_rdata,
    output logic [1:0]                      s_axi_lite_rresp,
    input  logic                            s_axi_lite_rready,
    output logic [2*NUM_CH*FIELD_W-1:0]     ring_base,
    output logic [2*NUM_CH*FIELD_W-1:0]     ring_high,
    output logic [2*NUM_CH*FIELD_W-1:0]     ring_size,
    output logic [2*NUM_CH-1:0]             ring_en,
    input  logic [2*NUM_CH-1:0]             ring_done,
    output logic                            irq
);

    localparam int NR = 2 * NUM_CH;
    localparam int RW = NR * FIELD_W;

    logic          wr_en, wr_err, rd_en, rd_err;
    logic [11:0]   wr_addr, rd_addr;
    logic [31:0]   wr_data, wr_mask, rd_data;
    logic [3:0]    wr_strb;
    ring_idx_t     wr_ring, rd_ring;
    logic          wr_ring_hit, rd_ring_hit, wr_glb, rd_glb;
    logic [RW-1:0] base_q, base_d, high_q, high_d, size_q, size_d;
    logic [NR-1:0] en_q, en_d, status_q, status_d, enable_q, enable_d, clr;
    logic          irq_q, irq_d;
    logic          unused_misc;

    dma_mmio_axil_if u_axil (
        .clk_i     (user_clk),
        .rst_i     (user_reset),
        .awvalid_i (s_axi_lite_awvalid),
        .awaddr_i  (s_axi_lite_awaddr),
        .awready_o (s_axi_lite_awready),
        .wvalid_i  (s_axi_lite_wvalid),
        .wdata_i   (s_axi_lite_wdata),
        .wstrb_i   (s_axi_lite_wstrb),
        .wready_o  (s_axi_lite_wready),
        .bvalid_o  (s_axi_lite_bvalid),
        .bresp_o   (s_axi_lite_bresp),
        .bready_i  (s_axi_lite_bready),
        .arvalid_i (s_axi_lite_arvalid),
        .araddr_i  (s_axi_lite_araddr),
        .arready_o (s_axi_lite_arready),
        .rvalid_o  (s_axi_lite_rvalid),
        .rdata_o   (s_axi_lite_rdata),
        .rresp_o   (s_axi_lite_rresp),
        .rready_i  (s_axi_lite_rready),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .wr_err_i  (wr_err),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data),
        .rd_err_i  (rd_err)
    );

`ifdef DMA_MMIO_WSTRB_EN
    assign wr_mask = strb_mask(wr_strb);
`else
    logic unused_strb;
    assign wr_mask     = 32'hFFFF_FFFF;
    assign unused_strb = ^wr_strb;
`endif
    assign unused_misc = ^{wr_addr[1:0], rd_addr[1:0], wr_data[4:0], wr_mask[4:0], rd_en};

    // Ring index checked 5 bits wide so that NR = 16 still decodes correctly.
    assign wr_ring     = ring_idx_t'(wr_addr[7:4]);
    assign rd_ring     = ring_idx_t'(rd_addr[7:4]);
    assign wr_ring_hit = (wr_addr[11:8] == 4'h0) && ({1'b0, wr_ring} < 5'(NR));
    assign rd_ring_hit = (rd_addr[11:8] == 4'h0) && ({1'b0, rd_ring} < 5'(NR));
    assign wr_glb      = (wr_addr[11:4] == GLB_BLOCK);
    assign rd_glb      = (rd_addr[11:4] == GLB_BLOCK);
    assign wr_err      = !(wr_ring_hit || (wr_glb && ((wr_addr[3:2] == GLB_IRQ_STATUS_OFF) ||
                                                      (wr_addr[3:2] == GLB_IRQ_ENABLE_OFF))));
    assign rd_err      = !(rd_ring_hit || (rd_glb && (rd_addr[3:2] != 2'd3)));

    // Register next state from the committed write and ring completion pulses.
    always_comb begin
        base_d   = base_q;
        high_d   = high_q;
        size_d   = size_q;
        en_d     = en_q;
        enable_d = enable_q;
        clr      = '0;
        if (wr_en && wr_ring_hit) begin
            for (int r = 0; r < NR; r++) begin
                if (wr_ring == 4'(r)) begin
                    case (wr_addr[3:2])
                        RING_BASE_OFF: base_d[r*FIELD_W +: FIELD_W] =
                            merge_field(base_q[r*FIELD_W +: FIELD_W], wr_data[31:5], wr_mask[31:5]);
                        RING_HIGH_OFF: high_d[r*FIELD_W +: FIELD_W] =
                            merge_field(high_q[r*FIELD_W +: FIELD_W], wr_data[31:5], wr_mask[31:5]);
                        RING_SIZE_OFF: size_d[r*FIELD_W +: FIELD_W] =
                            merge_field(size_q[r*FIELD_W +: FIELD_W], wr_data[31:5], wr_mask[31:5]);
                        RING_CTRL_OFF: en_d[r] = wr_mask[0] ? wr_data[0] : en_q[r];
                        default:       en_d[r] = en_q[r];
                    endcase
                end else begin
                    en_d[r] = en_q[r];
                end
            end
        end else if (wr_en && wr_glb && (wr_addr[3:2] == GLB_IRQ_ENABLE_OFF)) begin
            enable_d = (enable_q & ~wr_mask[NR-1:0]) | (wr_data[NR-1:0] & wr_mask[NR-1:0]);
        end else if (wr_en && wr_glb && (wr_addr[3:2] == GLB_IRQ_STATUS_OFF)) begin
            clr = wr_data[NR-1:0] & wr_mask[NR-1:0];
        end else begin
            clr = '0;
        end
        // A completion pulse wins over a simultaneous write-one-to-clear.
        status_d = (status_q & ~clr) | ring_done;
        irq_d    = |(status_q & enable_q);
    end

    // Read mux; unmapped offsets return zero.
    always_comb begin
        rd_data = 32'h0000_0000;
        if (rd_ring_hit) begin
            for (int r = 0; r < NR; r++) begin
                if (rd_ring == 4'(r)) begin
                    case (rd_addr[3:2])
                        RING_BASE_OFF: rd_data = {base_q[r*FIELD_W +: FIELD_W], 5'b00000};
                        RING_HIGH_OFF: rd_data = {high_q[r*FIELD_W +: FIELD_W], 5'b00000};
                        RING_SIZE_OFF: rd_data = {size_q[r*FIELD_W +: FIELD_W], 5'b00000};
                        default:       rd_data = {31'h0000_0000, en_q[r]};
                    endcase
                end else begin
                    rd_data = rd_data;
                end
            end
        end else if (rd_glb) begin
            case (rd_addr[3:2])
                GLB_VERSION_OFF:    rd_data = VERSION;
                GLB_IRQ_STATUS_OFF: rd_data = 32'(status_q);
                GLB_IRQ_ENABLE_OFF: rd_data = 32'(enable_q);
                default:            rd_data = 32'h0000_0000;
            endcase
        end else begin
            rd_data = 32'h0000_0000;
        end
    end

    // Register file state.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            base_q   <= '0;
            high_q   <= '0;
            size_q   <= '0;
            en_q     <= '0;
            status_q <= '0;
            enable_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            base_q   <= base_d;
            high_q   <= high_d;
            size_q   <= size_d;
            en_q     <= en_d;
            status_q <= status_d;
            enable_q <= enable_d;
            irq_q    <= irq_d;
        end
    end

    assign ring_base = base_q;
    assign ring_high = high_q;
    assign ring_size = size_q;
    assign ring_en   = en_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_dma_mmio_regfile.sv
// Directed self-checking bench for dma_mmio_regfile (NUM_CH = 2, four rings).
module tb_dma_mmio_regfile;

    logic         user_clk, user_reset;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [107:0] ring_base, ring_high, ring_size;
    logic [107:0] exp_base, exp_high, exp_size;
    logic [3:0]   ring_en, ring_done;
    logic         irq;
    logic [31:0]  strb_expect;
    int           n_checks = 0;
    int           n_fails  = 0;

    dma_mmio_regfile #(.NUM_CH(2), .VERSION(32'h0001_0000)) dut (
        .user_clk           (user_clk),
        .user_reset         (user_reset),
        .s_axi_lite_awvalid (awvalid),
        .s_axi_lite_awaddr  (awaddr),
        .s_axi_lite_awready (awready),
        .s_axi_lite_wvalid  (wvalid),
        .s_axi_lite_wdata   (wdata),
        .s_axi_lite_wstrb   (wstrb),
        .s_axi_lite_wready  (wready),
        .s_axi_lite_bvalid  (bvalid),
        .s_axi_lite_bresp   (bresp),
        .s_axi_lite_bready  (bready),
        .s_axi_lite_arvalid (arvalid),
        .s_axi_lite_araddr  (araddr),
        .s_axi_lite_arready (arready),
        .s_axi_lite_rvalid  (rvalid),
        .s_axi_lite_rdata   (rdata),
        .s_axi_lite_rresp   (rresp),
        .s_axi_lite_rready  (rready),
        .ring_base          (ring_base),
        .ring_high          (ring_high),
        .ring_size          (ring_size),
        .ring_en            (ring_en),
        .ring_done          (ring_done),
        .irq                (irq)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic send_aw(input logic [31:0] a, input string tag);
        int k = 0;
        awvalid = 1'b1;
        awaddr  = a;
        while (!awready && k < 20) begin
            @(negedge user_clk);
            k++;
        end
        check_eq({tag, "_awready"}, 128'(awready), 128'(1));
        @(posedge user_clk);
        @(negedge user_clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input string tag);
        int k = 0;
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        while (!wready && k < 20) begin
            @(negedge user_clk);
            k++;
        end
        check_eq({tag, "_wready"}, 128'(wready), 128'(1));
        @(posedge user_clk);
        @(negedge user_clk);
        wvalid = 1'b0;
    endtask

    task automatic wait_b(input logic [1:0] er, input string tag);
        int k = 0;
        bready = 1'b1;
        while (!bvalid && k < 20) begin
            @(negedge user_clk);
            k++;
        end
        check_eq({tag, "_bvalid"}, 128'(bvalid), 128'(1));
        check_eq({tag, "_bresp"}, 128'(bresp), 128'(er));
        @(posedge user_clk);
        @(negedge user_clk);
        bready = 1'b0;
        check_eq({tag, "_bvalid_clr"}, 128'(bvalid), 128'(0));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] er, input string tag);
        send_aw(a, tag);
        send_w(d, s, tag);
        wait_b(er, tag);
    endtask

    task automatic send_ar(input logic [31:0] a, input string tag);
        int k = 0;
        arvalid = 1'b1;
        araddr  = a;
        while (!arready && k < 20) begin
            @(negedge user_clk);
            k++;
        end
        check_eq({tag, "_arready"}, 128'(arready), 128'(1));
        @(posedge user_clk);
        @(negedge user_clk);
        arvalid = 1'b0;
        check_eq({tag, "_rvalid"}, 128'(rvalid), 128'(1));
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er, input string tag);
        send_ar(a, tag);
        check_eq({tag, "_rdata"}, 128'(rdata), 128'(ed));
        check_eq({tag, "_rresp"}, 128'(rresp), 128'(er));
        rready = 1'b1;
        @(posedge user_clk);
        @(negedge user_clk);
        rready = 1'b0;
        check_eq({tag, "_rvalid_clr"}, 128'(rvalid), 128'(0));
    endtask

    initial begin
        user_reset = 1'b1;
        {awvalid, wvalid, bready, arvalid, rready} = 5'b00000;
        awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0; ring_done = 4'h0;
        exp_base = '0; exp_high = '0; exp_size = '0;
        repeat (3) @(negedge user_clk);
        check_eq("rst_awready", 128'(awready), 128'(0));
        check_eq("rst_arready", 128'(arready), 128'(0));
        check_eq("rst_bvalid", 128'(bvalid), 128'(0));
        check_eq("rst_rvalid", 128'(rvalid), 128'(0));
        check_eq("rst_base", 128'(ring_base), 128'(0));
        check_eq("rst_irq", 128'(irq), 128'(0));
        user_reset = 1'b0;
        @(negedge user_clk);
        check_eq("rel_awready", 128'(awready), 128'(1));
        check_eq("rel_wready", 128'(wready), 128'(1));

        // Ring1 BASE, AW one cycle before W; commit lands one edge after the W handshake.
        send_aw(32'h0000_0010, "b1_aw");
        send_w(32'h1234_5660, 4'hF, "b1_w");
        check_eq("b1_precommit_base", 128'(ring_base), 128'(0));
        @(negedge user_clk);
        exp_base[27 +: 27] = 27'h091A2B3;
        check_eq("b1_base_out", 128'(ring_base), 128'(exp_base));
        check_eq("b1_field", 128'(ring_base[53:27]), 128'(27'h091A2B3));
        wait_b(2'b00, "b1_b");
        rd(32'h0000_0010, 32'h1234_5660, 2'b00, "b1_rd");
        rd(32'h0000_0800, 32'h0001_0000, 2'b00, "version_rd");

        // Unmapped and read-only targets.
        wr(32'h0000_0040, 32'hFFFF_FFE0, 4'hF, 2'b10, "ring4_wr");
        wr(32'h0000_0800, 32'hFFFF_FFFF, 4'hF, 2'b10, "version_wr");
        check_eq("err_base_out", 128'(ring_base), 128'(exp_base));
        check_eq("err_high_out", 128'(ring_high), 128'(exp_high));
        check_eq("err_en_out", 128'(ring_en), 128'(0));
        check_eq("err_irq", 128'(irq), 128'(0));
        rd(32'h0000_0040, 32'h0, 2'b10, "ring4_rd");
        rd(32'h0000_080C, 32'h0, 2'b10, "glb_c_rd");
        rd(32'h0000_0800, 32'h0001_0000, 2'b00, "version_rd2");
        rd(32'h0000_0030, 32'h0, 2'b00, "ring3_rd");

        // Interrupts.
        wr(32'h0000_0808, 32'h0000_0005, 4'hF, 2'b00, "ien_wr");
        rd(32'h0000_0808, 32'h0000_0005, 2'b00, "ien_rd");
        ring_done = 4'b0100;
        @(negedge user_clk);
        ring_done = 4'b0000;
        check_eq("irq_lag", 128'(irq), 128'(0));
        @(negedge user_clk);
        check_eq("irq_set", 128'(irq), 128'(1));
        rd(32'h0000_0804, 32'h0000_0004, 2'b00, "ists_rd");
        send_aw(32'h0000_0804, "w1c_race");
        send_w(32'h0000_0004, 4'hF, "w1c_race");
        ring_done = 4'b0100;
        @(negedge user_clk);
        ring_done = 4'b0000;
        wait_b(2'b00, "w1c_race");
        rd(32'h0000_0804, 32'h0000_0004, 2'b00, "w1c_race_rd");
        check_eq("irq_race", 128'(irq), 128'(1));
        wr(32'h0000_0804, 32'h0000_0004, 4'hF, 2'b00, "w1c");
        rd(32'h0000_0804, 32'h0000_0000, 2'b00, "w1c_rd");
        check_eq("irq_clr", 128'(irq), 128'(0));
        ring_done = 4'b0010;
        @(negedge user_clk);
        ring_done = 4'b0000;
        repeat (2) @(negedge user_clk);
        check_eq("irq_masked", 128'(irq), 128'(0));
        rd(32'h0000_0804, 32'h0000_0002, 2'b00, "masked_rd");

        // B backpressure with a second write captured behind it.
        send_aw(32'h0000_0004, "bp1");
        send_w(32'hAAAA_AAA0, 4'hF, "bp1");
        send_aw(32'h0000_0008, "bp2");
        send_w(32'h5555_5540, 4'hF, "bp2");
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_bvalid_hold", 128'(bvalid), 128'(1));
            check_eq("bp_bresp_hold", 128'(bresp), 128'(0));
            check_eq("bp_size_nocommit", 128'(ring_size), 128'(0));
            check_eq("bp_awready_full", 128'(awready), 128'(0));
            @(negedge user_clk);
        end
        exp_high[26:0] = 27'h5555555;
        check_eq("bp_high1", 128'(ring_high), 128'(exp_high));
        wait_b(2'b00, "bp_b1");
        check_eq("bp_size_still0", 128'(ring_size), 128'(0));
        wait_b(2'b00, "bp_b2");
        exp_size[26:0] = 27'h2AAAAAA;
        check_eq("bp_size2", 128'(ring_size), 128'(exp_size));
        rd(32'h0000_0008, 32'h5555_5540, 2'b00, "bp_size_rd");

        // Byte-lane strobes on ring2 BASE.
`ifdef DMA_MMIO_WSTRB_EN
        strb_expect = 32'h0000_FFE0;
`else
        strb_expect = 32'hFFFF_FFE0;
`endif
        wr(32'h0000_0020, 32'hFFFF_FFE0, 4'b0011, 2'b00, "strb_wr");
        rd(32'h0000_0020, strb_expect, 2'b00, "strb_rd");
        exp_base[54 +: 27] = strb_expect[31:5];
        check_eq("strb_base_out", 128'(ring_base), 128'(exp_base));

        // Reset in the middle of a read response and a half-received write.
        wr(32'h0000_001C, 32'h0000_0001, 4'hF, 2'b00, "ctrl_wr");
        check_eq("ctrl_en", 128'(ring_en), 128'(4'b0010));
        rd(32'h0000_001C, 32'h0000_0001, 2'b00, "ctrl_rd");
        send_ar(32'h0000_0010, "rst_ar");
        check_eq("rst_rdata_pending", 128'(rdata), 128'(32'h1234_5660));
        send_aw(32'h0000_0000, "rst_aw");
        user_reset = 1'b1;
        @(negedge user_clk);
        check_eq("mid_rvalid", 128'(rvalid), 128'(0));
        check_eq("mid_base", 128'(ring_base), 128'(0));
        check_eq("mid_high", 128'(ring_high), 128'(0));
        check_eq("mid_size", 128'(ring_size), 128'(0));
        check_eq("mid_en", 128'(ring_en), 128'(0));
        check_eq("mid_arready", 128'(arready), 128'(0));
        user_reset = 1'b0;
        @(negedge user_clk);
        check_eq("post_arready", 128'(arready), 128'(1));
        check_eq("post_awready", 128'(awready), 128'(1));
        send_w(32'hDEAD_BEE0, 4'hF, "post_w");
        repeat (2) @(negedge user_clk);
        check_eq("post_no_commit", 128'(bvalid), 128'(0));
        send_aw(32'h0000_0004, "post_aw");
        wait_b(2'b00, "post_b");
        rd(32'h0000_0004, 32'hDEAD_BEE0, 2'b00, "post_high_rd");
        rd(32'h0000_0000, 32'h0000_0000, 2'b00, "post_base_rd");
        rd(32'h0000_0010, 32'h0000_0000, 2'b00, "post_b1_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
